// File: rtl/seq_burst_controller.sv
// Round-robin burst controller sharing one 8-bit sequence generator between requesters.
// Each grant streams req_len generator beats on a valid/ready port tagged with the requester id.
module seq_burst_controller #(
    parameter int NUM_REQ          = 2,
    parameter int LEN_W            = 8,
    parameter int ID_W             = 1,
    parameter bit RESTART_ON_GRANT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_last,
    output logic [ID_W-1:0]          out_id,
    output logic                     seq_rst_n,
    output logic                     seq_enable,
    input  logic [7:0]               seq_data
);

    typedef enum logic [1:0] {
        IDLE,
        RESTART,
        BURST,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   id, id_next;
    logic [ID_W-1:0]   rr_ptr, rr_next;
    logic [LEN_W-1:0]  remaining, remaining_next;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [LEN_W-1:0]  winner_len;
    logic              found_hi;
    logic [ID_W-1:0]   winner_hi;
    logic [ID_W-1:0]   winner_lo;

    // Round robin: lowest requester above the last served one, else lowest overall.
    always_comb begin
        found     = 1'b0;
        found_hi  = 1'b0;
        winner_hi = '0;
        winner_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found     = 1'b1;
                winner_lo = ID_W'(i);
                if (i > int'(rr_ptr)) begin
                    found_hi  = 1'b1;
                    winner_hi = ID_W'(i);
                end
            end
        end
        winner     = found_hi ? winner_hi : winner_lo;
        winner_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                winner_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_next     = state;
        id_next        = id;
        rr_next        = rr_ptr;
        remaining_next = remaining;
        grant          = '0;
        done           = '0;
        out_valid      = 1'b0;
        out_data       = 8'h00;
        out_last       = 1'b0;
        out_id         = '0;
        seq_rst_n      = !reset;
        seq_enable     = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    id_next        = winner;
                    remaining_next = winner_len;
                    if (winner_len == '0) begin
                        state_next = DONE;
                    end else if (RESTART_ON_GRANT) begin
                        state_next = RESTART;
                    end else begin
                        state_next = BURST;
                    end
                end
            end
            RESTART: begin
                grant      = NUM_REQ'(1) << id;
                out_id     = id;
                seq_rst_n  = 1'b0;
                state_next = BURST;
            end
            BURST: begin
                grant      = NUM_REQ'(1) << id;
                out_valid  = 1'b1;
                out_data   = seq_data;
                out_id     = id;
                out_last   = (remaining == LEN_W'(1));
                // The generator only steps when a beat is consumed, so stalls hold out_data.
                seq_enable = out_ready;
                if (out_ready) begin
                    remaining_next = remaining - LEN_W'(1);
                    if (out_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = NUM_REQ'(1) << id;
                rr_next    = id;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state     <= IDLE;
            id        <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            remaining <= '0;
        end else begin
            state     <= state_next;
            id        <= id_next;
            rr_ptr    <= rr_next;
            remaining <= remaining_next;
        end
    end

endmodule

// File: tb/tb_seq_burst_controller.sv
// Scoreboard bench for seq_burst_controller with a behavioural sequence generator model.
// Directed tests queue expected beats and done pulses; a monitor pops beats on every transfer.
module tb_seq_burst_controller;

    localparam int NUM_REQ = 2;
    localparam int LEN_W   = 8;
    localparam int ID_W    = 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_data;
    logic                     out_last;
    logic [ID_W-1:0]          out_id;
    logic                     seq_rst_n;
    logic                     seq_enable;
    logic [7:0]               seq_data;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         id;
    } beat_t;

    beat_t exp_q[$];
    int    done_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    en_cnt   = 0;

    seq_burst_controller #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .ID_W(ID_W), .RESTART_ON_GRANT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .grant(grant), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_id(out_id), .seq_rst_n(seq_rst_n), .seq_enable(seq_enable), .seq_data(seq_data)
    );

    always #5 clk = ~clk;

    // Generator model: synchronous active-low reset, one pattern step per enabled cycle.
    logic [2:0] gen_idx;
    always @(posedge clk) begin
        if (!seq_rst_n)     gen_idx <= 3'd0;
        else if (seq_enable) gen_idx <= gen_idx + 3'd1;
    end
    always_comb begin
        case (gen_idx)
            3'd0: seq_data = 8'hAF;
            3'd1: seq_data = 8'hBC;
            3'd2: seq_data = 8'hE2;
            3'd3: seq_data = 8'h78;
            3'd4: seq_data = 8'hFF;
            3'd5: seq_data = 8'hE2;
            3'd6: seq_data = 8'h0B;
            default: seq_data = 8'h8D;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int id, input logic [7:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        b.id   = id;
        exp_q.push_back(b);
    endtask

    // Beats are listed left-aligned in bytes, first beat in the top byte.
    task automatic push_burst(input int id, input int n, input logic [79:0] bytes);
        for (int k = 0; k < n; k++) begin
            push_beat(id, bytes[79-8*k -: 8], k == n - 1);
        end
        done_q.push_back(id);
    endtask

    task automatic wait_xfer();
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) seen = 1'b1;
        end
        if (!seen) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    // Waits for n done pulses, checks them against the queue, and drops the served req.
    task automatic wait_done(input int n);
        int                 got       = 0;
        int                 cyc       = 0;
        logic               prev_last = 1'b0;
        logic [NUM_REQ-1:0] d;
        int                 e;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                d = done;
                if (done_q.size() > 0) begin
                    e = done_q.pop_front();
                    check("done_vector", 32'(d), 32'd1 << e);
                end else begin
                    check("done_unexpected", 32'(d), 32'd0);
                end
                check("done_after_last", 32'(prev_last), 32'd1);
                got++;
                tick();
                req       = req & ~d;
                prev_last = 1'b0;
            end else begin
                prev_last = out_valid && out_ready && out_last && !reset;
            end
        end
        if (got < n) check("done_timeout", got, n);
    endtask

    // Beat monitor: every accepted beat must match the head of the scoreboard.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (seq_enable) en_cnt++;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_last", 32'(out_last), 32'(b.last));
                    check("beat_id", 32'(out_id), b.id);
                    check("beat_grant", 32'(grant), 32'd1 << b.id);
                end
            end else if (!reset && !out_valid) begin
                check("idle_data", {23'd0, out_last, out_data}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_len   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_seq_rst_n", 32'(seq_rst_n), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {grant, done, out_valid, out_last, out_id, seq_enable}, 32'd0);
        check("idle_seq_rst_n", 32'(seq_rst_n), 32'd1);

        // Test 1: req0 len 3 with restart, latency and RESTART cycle checked explicitly.
        tick();
        req_len = {8'd0, 8'd3};
        req     = 2'b01;
        push_burst(0, 3, {24'hAFBCE2, 56'h0});
        @(negedge clk);
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_restart_rst_n", 32'(seq_rst_n), 32'd0);
        check("t1_restart_grant", 32'(grant), 32'd1);
        check("t1_restart_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_data", 32'(out_data), 32'hAF);
        wait_done(1);

        // Test 2: req1 len 10 wraps the pattern; exactly 10 enable cycles.
        begin
            int e0;
            e0 = en_cnt;
            tick();
            req_len = {8'd10, 8'd0};
            req     = 2'b10;
            push_burst(1, 10, 80'hAFBCE278FFE20B8DAFBC);
            wait_done(1);
            check("t2_enable_cycles", en_cnt - e0, 32'd10);
        end

        // Test 3: simultaneous requests at reset release alternate 0,1,0,1.
        reset   = 1'b1;
        req     = 2'b11;
        req_len = {8'd3, 8'd2};
        push_burst(0, 2, {16'hAFBC, 64'h0});
        push_burst(1, 3, {24'hAFBCE2, 56'h0});
        repeat (2) tick();
        reset = 1'b0;
        wait_done(2);
        tick();
        req = 2'b11;
        push_burst(0, 2, {16'hAFBC, 64'h0});
        push_burst(1, 3, {24'hAFBCE2, 56'h0});
        wait_done(2);

        // Test 4: stall for 3 cycles while the second beat is presented.
        tick();
        req_len = {8'd0, 8'd4};
        req     = 2'b01;
        push_burst(0, 4, {32'hAFBCE278, 48'h0});
        wait_xfer();
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_stall_data", 32'(out_data), 32'hBC);
            check("t4_stall_enable", 32'(seq_enable), 32'd0);
            check("t4_stall_valid", 32'(out_valid), 32'd1);
        end
        tick();
        out_ready = 1'b1;
        wait_done(1);

        // Test 5: zero-length burst goes straight to done without beats or restart.
        tick();
        req_len = '0;
        req     = 2'b01;
        @(negedge clk);
        check("t5_idle_rst_n", 32'(seq_rst_n), 32'd1);
        @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        check("t5_rst_n", 32'(seq_rst_n), 32'd1);
        check("t5_grant", 32'(grant), 32'd0);
        tick();
        req = 2'b00;
        @(negedge clk);
        check("t5_done_cleared", 32'(done), 32'd0);

        // Test 6: reset during beat 2 of a len-8 burst abandons it with no done.
        tick();
        req_len = {8'd0, 8'd8};
        req     = 2'b01;
        push_beat(0, 8'hAF, 1'b0);
        wait_xfer();
        tick();
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        check("t6_gen_held", 32'(seq_rst_n), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_idle_outputs", {grant, done, out_valid, out_last, out_id, seq_enable}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_done", 32'(done), 32'd0);
        end
        tick();
        req_len = {8'd0, 8'd2};
        req     = 2'b01;
        push_burst(0, 2, {16'hAFBC, 64'h0});
        wait_done(1);

        tick();
        check("beats_outstanding", exp_q.size(), 32'd0);
        check("dones_outstanding", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
